// File: rtl/aes_block_feeder.sv
// Packs 32-bit key and plaintext words into 128-bit cipher buses, strobes a launch per
// block and tracks each block through the fixed cipher latency to produce out_valid_o.
module aes_block_feeder #(
    parameter  int LATENCY = 10,
    localparam int IW      = $clog2(LATENCY + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           key_valid_i,
    input  logic [31:0]    key_word_i,
    output logic           key_ready_o,
    input  logic           in_valid_i,
    input  logic [31:0]    in_word_i,
    output logic           in_ready_o,
    output logic [127:0]   cipher_datain_o,
    output logic [127:0]   cipher_key_o,
    output logic           launch_o,
    output logic           out_valid_o,
    output logic           key_loaded_o,
    output logic [1:0]     key_cnt_o,
    output logic [1:0]     word_cnt_o,
    output logic [IW-1:0]  inflight_o
);

    // Handshake: a word transfers on a rising edge where valid and ready are both high;
    // the source holds word and valid stable until that edge.
    logic [1:0]         key_cnt_q,    key_cnt_d;
    logic [95:0]        key_shadow_q, key_shadow_d;
    logic [127:0]       cipher_key_q, cipher_key_d;
    logic               key_loaded_q, key_loaded_d;
    logic [1:0]         word_cnt_q,   word_cnt_d;
    logic [95:0]        stage_q,      stage_d;
    logic [127:0]       datain_q,     datain_d;
    logic               launch_q,     launch_d;
    logic [LATENCY-1:0] sr_q,         sr_d;
    logic [IW-1:0]      inflight_q,   inflight_d;
    logic               key_acc;
    logic               in_acc;
    logic               out_valid;

    assign out_valid   = sr_q[LATENCY-1];
    // Keys may only change between blocks with the cipher drained; a key offer wins
    // over a data offer in the same cycle.
    assign key_ready_o = (word_cnt_q == 2'd0) && (inflight_q == '0);
    assign key_acc     = key_valid_i && key_ready_o;
    assign in_ready_o  = key_loaded_q && (key_cnt_q == 2'd0) && !key_acc;
    assign in_acc      = in_valid_i && in_ready_o;

    always_comb begin
        key_cnt_d    = key_cnt_q;
        key_shadow_d = key_shadow_q;
        cipher_key_d = cipher_key_q;
        key_loaded_d = key_loaded_q;
        word_cnt_d   = word_cnt_q;
        stage_d      = stage_q;
        datain_d     = datain_q;
        launch_d     = 1'b0;
        inflight_d   = inflight_q;

        if (key_acc) begin
            key_cnt_d = key_cnt_q + 2'd1;
            case (key_cnt_q)
                2'd0:    key_shadow_d[95:64] = key_word_i;
                2'd1:    key_shadow_d[63:32] = key_word_i;
                2'd2:    key_shadow_d[31:0]  = key_word_i;
                default: begin
                    cipher_key_d = {key_shadow_q, key_word_i};
                    key_loaded_d = 1'b1;
                end
            endcase
        end

        if (in_acc) begin
            word_cnt_d = word_cnt_q + 2'd1;
            case (word_cnt_q)
                2'd0:    stage_d[95:64] = in_word_i;
                2'd1:    stage_d[63:32] = in_word_i;
                2'd2:    stage_d[31:0]  = in_word_i;
                default: begin
                    datain_d = {stage_q, in_word_i};
                    launch_d = 1'b1;
                end
            endcase
        end

        // Tag pipeline mirrors the cipher's latency; the bit falling out is out_valid.
        sr_d    = sr_q << 1;
        sr_d[0] = launch_q;

        case ({launch_q, out_valid})
            2'b10:   inflight_d = inflight_q + IW'(1);
            2'b01:   inflight_d = inflight_q - IW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_cnt_q    <= '0;
            key_shadow_q <= '0;
            cipher_key_q <= '0;
            key_loaded_q <= 1'b0;
            word_cnt_q   <= '0;
            stage_q      <= '0;
            datain_q     <= '0;
            launch_q     <= 1'b0;
            sr_q         <= '0;
            inflight_q   <= '0;
        end else begin
            key_cnt_q    <= key_cnt_d;
            key_shadow_q <= key_shadow_d;
            cipher_key_q <= cipher_key_d;
            key_loaded_q <= key_loaded_d;
            word_cnt_q   <= word_cnt_d;
            stage_q      <= stage_d;
            datain_q     <= datain_d;
            launch_q     <= launch_d;
            sr_q         <= sr_d;
            inflight_q   <= inflight_d;
        end
    end

    assign cipher_datain_o = datain_q;
    assign cipher_key_o    = cipher_key_q;
    assign launch_o        = launch_q;
    assign out_valid_o     = out_valid;
    assign key_loaded_o    = key_loaded_q;
    assign key_cnt_o       = key_cnt_q;
    assign word_cnt_o      = word_cnt_q;
    assign inflight_o      = inflight_q;

endmodule

// File: tb/tb_aes_block_feeder.sv
// Bench for aes_block_feeder: directed scenarios with random words, a queue-based
// reference model, and a cipher stand-in that delays cipher_datain by LATENCY cycles.
module tb_aes_block_feeder;
    localparam int LAT = 10;
    localparam int IW  = $clog2(LAT + 1);
    localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] FIPS_K  = 128'h000102030405060708090a0b0c0d0e0f;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          key_valid = 1'b0, in_valid = 1'b0;
    logic [31:0]   key_word = '0, in_word = '0;
    logic          key_ready, in_ready, launch, out_valid, key_loaded;
    logic [127:0]  cipher_datain, cipher_key;
    logic [1:0]    key_cnt, word_cnt;
    logic [IW-1:0] inflight;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    aes_block_feeder #(.LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .key_valid_i(key_valid), .key_word_i(key_word), .key_ready_o(key_ready),
        .in_valid_i(in_valid), .in_word_i(in_word), .in_ready_o(in_ready),
        .cipher_datain_o(cipher_datain), .cipher_key_o(cipher_key),
        .launch_o(launch), .out_valid_o(out_valid), .key_loaded_o(key_loaded),
        .key_cnt_o(key_cnt), .word_cnt_o(word_cnt), .inflight_o(inflight)
    );

    // ---------------- clock / reset block ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Cipher stand-in: known answer for the FIPS-197 plaintext, inverted data otherwise.
    logic [127:0] pipe [LAT];
    logic [127:0] stub_dout;
    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
        pipe[0] <= cipher_datain;
    end
    assign stub_dout = (pipe[LAT-1] == FIPS_PT) ? FIPS_CT : ~pipe[LAT-1];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard / reference model ----------------
    logic [31:0]  kw_q[$], dw_q[$];
    logic [127:0] exp_q[$], out_blk_q[$];
    int           launch_at_q[$], out_at_q[$];
    int           obs_launch[$], obs_out[$];
    logic [127:0] m_key = '0, m_data = '0, ob, last_dout = '0;
    bit           m_loaded = 1'b0, exp_l, exp_o, exp_kr, exp_ir;
    int           m_infl = 0, peak = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            kw_q.delete(); dw_q.delete(); exp_q.delete(); out_blk_q.delete();
            launch_at_q.delete(); out_at_q.delete();
            m_key = '0; m_data = '0; m_loaded = 1'b0; m_infl = 0;
            chk("rst_launch", 128'(launch), 128'(0));
            chk("rst_out_valid", 128'(out_valid), 128'(0));
            chk("rst_key_ready", 128'(key_ready), 128'(1));
            chk("rst_in_ready", 128'(in_ready), 128'(0));
            chk("rst_datain", cipher_datain, '0);
        end else begin
            exp_l = launch_at_q.size() > 0 && launch_at_q[0] == cyc;
            exp_o = out_at_q.size() > 0 && out_at_q[0] == cyc;
            if (exp_l) begin
                void'(launch_at_q.pop_front());
                m_data = exp_q.pop_front();
                out_at_q.push_back(cyc + LAT);
                out_blk_q.push_back(m_data);
            end
            exp_kr = dw_q.size() == 0 && m_infl == 0;
            exp_ir = m_loaded && kw_q.size() == 0 && !(key_valid && exp_kr);
            chk("launch", 128'(launch), 128'(exp_l));
            chk("out_valid", 128'(out_valid), 128'(exp_o));
            chk("cipher_key", cipher_key, m_key);
            chk("cipher_datain", cipher_datain, m_data);
            chk("key_loaded", 128'(key_loaded), 128'(m_loaded));
            chk("key_ready", 128'(key_ready), 128'(exp_kr));
            chk("in_ready", 128'(in_ready), 128'(exp_ir));
            chk("inflight", 128'(inflight), 128'(m_infl));
            if (exp_o) begin
                void'(out_at_q.pop_front());
                ob = out_blk_q.pop_front();
                chk("cipher_dout", stub_dout, (ob == FIPS_PT) ? FIPS_CT : ~ob);
            end
            m_infl += int'(exp_l) - int'(exp_o);
            if (key_valid && exp_kr) begin
                kw_q.push_back(key_word);
                if (kw_q.size() == 4) begin
                    m_key = {kw_q[0], kw_q[1], kw_q[2], kw_q[3]};
                    m_loaded = 1'b1;
                    kw_q.delete();
                end
            end
            if (in_valid && exp_ir) begin
                dw_q.push_back(in_word);
                if (dw_q.size() == 4) begin
                    exp_q.push_back({dw_q[0], dw_q[1], dw_q[2], dw_q[3]});
                    launch_at_q.push_back(cyc + 1);
                    dw_q.delete();
                end
            end
            if (launch) obs_launch.push_back(cyc);
            if (out_valid) begin
                obs_out.push_back(cyc);
                last_dout = stub_dout;
            end
            if (int'(inflight) > peak) peak = int'(inflight);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_key(input logic [31:0] w, input int gap, output int acc_c);
        bit acc = 1'b0;
        key_valid = 1'b0;
        idle(gap);
        key_valid = 1'b1; key_word = w; acc_c = -1;
        for (int i = 0; i < 300 && !acc; i++) begin
            @(negedge clk); acc = key_ready; acc_c = cyc;
            @(posedge clk); #1;
        end
        key_valid = 1'b0;
        chk("key_accept_bound", 128'(acc), 128'(1));
    endtask

    task automatic send_word(input logic [31:0] w, input int gap, output int acc_c);
        bit acc = 1'b0;
        in_valid = 1'b0;
        idle(gap);
        in_valid = 1'b1; in_word = w; acc_c = -1;
        for (int i = 0; i < 300 && !acc; i++) begin
            @(negedge clk); acc = in_ready; acc_c = cyc;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("word_accept_bound", 128'(acc), 128'(1));
    endtask

    task automatic wait_outs(input int n);
        for (int i = 0; i < 300 && obs_out.size() < n; i++) @(posedge clk);
        #1;
        chk("out_wait_bound", 128'(obs_out.size()), 128'(n));
    endtask

    // ---------------- directed steps ----------------
    logic [31:0]  kw [4];
    logic [31:0]  dw [4];
    logic [127:0] fips_k, fips_p;
    int           ac, k_last, w_first, n0, m0;

    initial begin
        fips_k = FIPS_K;
        fips_p = FIPS_PT;
        idle(3);
        rst_n = 1'b1;
        idle(2);

        // FIPS-197 vector
        for (int i = 0; i < 4; i++) send_key(fips_k[127 - 32*i -: 32], 0, k_last);
        send_word(fips_p[127:96], 0, w_first);
        chk("key_to_first_word", 128'(w_first), 128'(k_last + 1));
        for (int i = 1; i < 4; i++) send_word(fips_p[127 - 32*i -: 32], 0, ac);
        wait_outs(1);
        chk("fips_key", cipher_key, FIPS_K);
        chk("fips_datain", cipher_datain, FIPS_PT);
        chk("fips_launch_count", 128'(obs_launch.size()), 128'(1));
        chk("fips_latency", 128'(obs_out[0] - obs_launch[0]), 128'(LAT));
        chk("fips_dout", last_dout, FIPS_CT);
        idle(3);

        // Back-to-back: three blocks with in_valid held high
        n0 = obs_launch.size(); m0 = obs_out.size(); peak = 0;
        for (int i = 0; i < 12; i++) send_word($urandom, 0, ac);
        wait_outs(m0 + 3);
        chk("b2b_launch_gap1", 128'(obs_launch[n0+1] - obs_launch[n0]), 128'(4));
        chk("b2b_launch_gap2", 128'(obs_launch[n0+2] - obs_launch[n0+1]), 128'(4));
        chk("b2b_out_gap1", 128'(obs_out[m0+1] - obs_out[m0]), 128'(4));
        chk("b2b_out_gap2", 128'(obs_out[m0+2] - obs_out[m0+1]), 128'(4));
        chk("b2b_latency", 128'(obs_out[m0] - obs_launch[n0]), 128'(LAT));
        chk("b2b_peak", 128'(peak), 128'((LAT + 3) / 4));
        idle(1);
        chk("b2b_drained", 128'(inflight), 128'(0));

        // Bubbles: key gap after word 1, random data gaps
        for (int i = 0; i < 4; i++) kw[i] = $urandom;
        for (int i = 0; i < 4; i++) send_key(kw[i], (i == 2) ? 3 : 0, ac);
        for (int i = 0; i < 4; i++) begin
            dw[i] = $urandom;
            send_word(dw[i], $urandom_range(0, 2), ac);
        end
        wait_outs(obs_out.size() + 1);
        chk("bubble_key", cipher_key, {kw[0], kw[1], kw[2], kw[3]});
        chk("bubble_datain", cipher_datain, {dw[0], dw[1], dw[2], dw[3]});

        // Re-key blocking: key offered while two blocks are in the cipher
        for (int i = 0; i < 8; i++) send_word($urandom, 0, ac);
        for (int i = 0; i < 4; i++) kw[i] = $urandom;
        send_key(kw[0], 0, ac);
        chk("rekey_after_last_out", 128'(ac), 128'(obs_out[$] + 1));
        for (int i = 1; i < 4; i++) send_key(kw[i], 0, ac);
        idle(1);
        chk("rekey_loaded", cipher_key, {kw[0], kw[1], kw[2], kw[3]});

        // Simultaneous key and data offers while idle
        idle(2);
        key_valid = 1'b1; key_word = $urandom; in_valid = 1'b1; in_word = $urandom;
        @(negedge clk);
        chk("simul_in_ready", 128'(in_ready), 128'(0));
        chk("simul_key_ready", 128'(key_ready), 128'(1));
        @(posedge clk); #1;
        key_valid = 1'b0; in_valid = 1'b0;
        chk("simul_word_cnt", 128'(word_cnt), 128'(0));
        chk("simul_key_cnt", 128'(key_cnt), 128'(1));
        for (int i = 0; i < 3; i++) send_key($urandom, 0, ac);
        for (int i = 0; i < 4; i++) send_word($urandom, $urandom_range(0, 1), ac);
        wait_outs(obs_out.size() + 1);

        // Reset mid-run: one block in flight, one partial block staged
        for (int i = 0; i < 4; i++) send_word($urandom, 0, ac);
        idle(2);
        for (int i = 0; i < 2; i++) send_word($urandom, 0, ac);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_key", cipher_key, '0);
        chk("rst_async_datain", cipher_datain, '0);
        chk("rst_async_launch", 128'(launch), 128'(0));
        chk("rst_async_key_loaded", 128'(key_loaded), 128'(0));
        chk("rst_async_key_ready", 128'(key_ready), 128'(1));
        chk("rst_async_in_ready", 128'(in_ready), 128'(0));
        idle(2);
        rst_n = 1'b1;
        n0 = obs_out.size();
        idle(2 * LAT);
        chk("rst_no_out_valid", 128'(obs_out.size()), 128'(n0));
        chk("rst_key_loaded", 128'(key_loaded), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
